// File: rtl/token_linear_proj.sv
// Linear projection y = x*W + b over a 16x16 Q4.4 token matrix.
// Uses one time-shared 8x8 MAC and saturates each result back to Q4.4.
module token_linear_proj #(
  parameter int N_TOK = 16,
  parameter int D     = 16,
  parameter int FRAC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] x [0:N_TOK-1][0:D-1],
  input  logic signed [7:0] w [0:D*D-1],
  input  logic signed [7:0] b [0:D-1],
  output logic signed [7:0] y [0:N_TOK-1][0:D-1],
  output logic              busy,
  output logic              done
);

  localparam int TW   = (N_TOK > 1) ? $clog2(N_TOK) : 1;
  localparam int DW   = (D > 1) ? $clog2(D) : 1;
  localparam int WIW  = (D > 1) ? $clog2(D*D) : 1;
  localparam int ACCW = 20;

  localparam logic signed [ACCW-1:0] MAXV = 127;
  localparam logic signed [ACCW-1:0] MINV = -128;

  typedef enum logic [1:0] {IDLE, MAC, WR, DONE_PULSE} state_t;

  state_t state, state_nxt;

  logic signed [7:0]      xb [0:N_TOK-1][0:D-1];
  logic signed [ACCW-1:0] acc;
  logic [TW-1:0]          t;
  logic [DW-1:0]          o;
  logic [DW-1:0]          k;

  logic [WIW-1:0]         widx;
  logic signed [15:0]     prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] shr;
  logic signed [7:0]      sat_val;
  logic [DW-1:0]          o_nxt;
  logic                   last_elem;

  // Bias is preloaded into the accumulator already aligned to Q8.8.
  function automatic logic signed [ACCW-1:0] bias_acc(input logic signed [7:0] bv);
    return {{(ACCW-8-FRAC){bv[7]}}, bv, {FRAC{1'b0}}};
  endfunction

  assign widx      = WIW'(int'(k) * D + int'(o));
  assign prod      = xb[t][k] * w[widx];
  assign prod_ext  = {{(ACCW-16){prod[15]}}, prod};
  assign shr       = acc >>> FRAC;
  assign o_nxt     = (o == DW'(D-1)) ? '0 : o + 1'b1;
  assign last_elem = (t == TW'(N_TOK-1)) && (o == DW'(D-1));

  always_comb begin
    sat_val = shr[7:0];
    if (shr > MAXV)
      sat_val = 8'sh7F;
    else if (shr < MINV)
      sat_val = 8'sh80;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = MAC;
      end
      MAC: begin
        if (k == DW'(D-1))
          state_nxt = WR;
      end
      WR: begin
        if (last_elem)
          state_nxt = DONE_PULSE;
        else
          state_nxt = MAC;
      end
      DONE_PULSE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: x is captured on start; w and b are read live during the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TOK; i++) begin
        for (int j = 0; j < D; j++) begin
          xb[i][j] <= '0;
          y[i][j]  <= '0;
        end
      end
      acc <= '0;
      t   <= '0;
      o   <= '0;
      k   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xb  <= x;
            t   <= '0;
            o   <= '0;
            k   <= '0;
            acc <= bias_acc(b[0]);
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= (k == DW'(D-1)) ? '0 : k + 1'b1;
        end
        WR: begin
          y[t][o] <= sat_val;
          o       <= o_nxt;
          if (o == DW'(D-1))
            t <= (t == TW'(N_TOK-1)) ? '0 : t + 1'b1;
          acc <= bias_acc(b[o_nxt]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_token_linear_proj.sv
// Scoreboard bench for token_linear_proj: stimulus pushes reference results,
// a negedge monitor pops and compares them whenever done is raised.
module tb_token_linear_proj;

  localparam int N_TOK      = 16;
  localparam int D          = 16;
  localparam int FRAC       = 4;
  localparam int RUN_CYCLES = N_TOK * D * (D + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [7:0] x [0:N_TOK-1][0:D-1];
  logic signed [7:0] w [0:D*D-1];
  logic signed [7:0] b [0:D-1];
  logic signed [7:0] y [0:N_TOK-1][0:D-1];
  logic              busy;
  logic              done;

  int cyc  = 0;
  int c0   = 0;
  int nvec = 0;
  int nerr = 0;

  logic signed [7:0] exp_q [$];
  int                done_q [$];
  logic              prev_done = 1'b0;

  token_linear_proj #(.N_TOK(N_TOK), .D(D), .FRAC(FRAC)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .w    (w),
    .b    (b),
    .y    (y),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: full-precision dot product, floor shift, clamp to 8 bits.
  function automatic logic signed [7:0] refElem(input int t, input int o);
    int s;
    s = int'(b[o]) * (1 << FRAC);
    for (int k = 0; k < D; k++)
      s += int'(x[t][k]) * int'(w[k*D+o]);
    s = s >>> FRAC;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  task automatic randomizeX();
    for (int t = 0; t < N_TOK; t++)
      for (int k = 0; k < D; k++)
        x[t][k] = 8'($urandom());
  endtask

  task automatic setPattern(input int kind);
    for (int t = 0; t < N_TOK; t++)
      for (int k = 0; k < D; k++)
        x[t][k] = '0;
    for (int i = 0; i < D*D; i++) w[i] = '0;
    for (int o = 0; o < D; o++) b[o] = '0;
    case (kind)
      0: begin
        randomizeX();
        for (int i = 0; i < D*D; i++) w[i] = (i / D == i % D) ? 8'sh10 : 8'sh00;
      end
      1: begin
        randomizeX();
        for (int o = 0; o < D; o++) b[o] = 8'(o - 8);
      end
      2, 3: begin
        for (int t = 0; t < N_TOK; t++)
          for (int k = 0; k < D; k++)
            x[t][k] = (kind == 2) ? 8'sh7F : 8'sh80;
        for (int i = 0; i < D*D; i++) w[i] = 8'sh7F;
        for (int o = 0; o < D; o++) b[o] = (kind == 2) ? 8'sh7F : 8'sh80;
      end
      4, 5: begin
        x[0][0] = (kind == 4) ? 8'sh01 : 8'shFF;
        w[0]    = 8'sh08;
      end
      6: begin
        randomizeX();
        for (int i = 0; i < D*D; i++) w[i] = 8'(int'($urandom_range(0, 47)) - 24);
        for (int o = 0; o < D; o++) b[o] = 8'($urandom());
      end
      default: begin
        randomizeX();
        for (int i = 0; i < D*D; i++) w[i] = 8'($urandom());
        for (int o = 0; o < D; o++) b[o] = 8'($urandom());
      end
    endcase
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    for (int t = 0; t < N_TOK; t++)
      for (int o = 0; o < D; o++)
        exp_q.push_back(refElem(t, o));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    done_q.push_back(c0 + RUN_CYCLES);
  endtask

  task automatic waitDone();
    int busy_cnt = 0;
    bit seen = 1'b0;
    for (int i = 0; i < RUN_CYCLES + 100; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", int'(seen), 1);
    checkOutput("busy_cycles", busy_cnt, RUN_CYCLES + 1);
    @(negedge clk);
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("done_after_done", int'(done), 0);
  endtask

  task automatic checkResetState(input string tag);
    int nz = 0;
    for (int t = 0; t < N_TOK; t++)
      for (int o = 0; o < D; o++)
        if (y[t][o] !== 8'sh00) nz++;
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_y_nonzero"}, nz, 0);
  endtask

  // Monitor: every done pulse must be expected, on time, one cycle wide,
  // and present the full reference matrix.
  always @(negedge clk) begin
    if (done) begin
      checkOutput("done_single_cycle", int'(prev_done), 0);
      if (done_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        checkOutput("done_cycle", cyc, done_q.pop_front());
        for (int t = 0; t < N_TOK; t++)
          for (int o = 0; o < D; o++)
            checkOutput($sformatf("y[%0d][%0d]", t, o), int'(y[t][o]), int'(exp_q.pop_front()));
      end
    end
    prev_done = done;
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    setPattern(4);
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    for (int kind = 0; kind <= 5; kind++) begin
      setPattern(kind);
      applyStimulus();
      waitDone();
    end

    // Buffered x plus ignored start pulses, then a back-to-back start.
    setPattern(6);
    applyStimulus();
    for (int n = 0; n <= RUN_CYCLES; n++) begin
      @(negedge clk);
      randomizeX();
      start = (cyc == c0 + 10) || (cyc == c0 + 2000) || (cyc == c0 + RUN_CYCLES);
    end
    applyStimulus();
    waitDone();

    // Abort mid-run with reset; the pending expectation is withdrawn.
    setPattern(7);
    applyStimulus();
    repeat (999) @(negedge clk);
    checkOutput("busy_mid_run", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkResetState("abort");
    void'(done_q.pop_back());
    repeat (N_TOK * D) void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("idle_after_abort", int'(busy), 0);

    setPattern(6);
    applyStimulus();
    waitDone();

    checkOutput("pending_done_queue", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/token_linear_proj.md
Name: token_linear_proj

Overview:
Downstream consumer of the 16x16 Q4.4 token matrix produced by the patch-embedding / positional stage. On a start pulse it latches the token matrix and computes one linear projection y = x·W + b, Q/K/V style, using a single time-shared 8x8 MAC. It saturates the results back to Q4.4 and raises a one-cycle done pulse when the full output matrix is valid. Multiple instances, one per Q, K and V weight set, feed the attention stage.

Parameters:
N_TOK, 16, number of tokens (rows of x and y)
D, 16, embedding width (columns of x; rows and columns of W)
FRAC, 4, fractional bits of the Q-format on x, W, b and y

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
x  input  8 signed [0:N_TOK-1][0:D-1]  token matrix, Q4.4
w  input  8 signed [0:D*D-1]  weights, index k*D+o (input k, output o), Q4.4
b  input  8 signed [0:D-1]  bias per output column, Q4.4
y  output  8 signed [0:N_TOK-1][0:D-1]  projected matrix, Q4.4
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; y complete

Behaviour:
- Reset (async, rst=1): state=IDLE; y all 0; busy=0; done=0; internal x buffer, accumulator and t/o/k counters all 0.
- States: IDLE, MAC, WR, DONE_PULSE.
- IDLE:
  - start=1 at a clock edge: copy x into internal buffer xb; t=o=k=0; acc = sign-extended b[0] << FRAC; next state MAC.
  - start=0: remain in IDLE.
- MAC:
  - acc <= acc + xb[t][k]*w[k*D+o].
  - Product is a full 16-bit signed (Q8.8) value; acc is 20-bit signed.
  - k increments each cycle; at k==D-1, k returns to 0 and next state is WR.
- WR:
  - y[t][o] <= sat8(acc >>> FRAC). The shift is arithmetic (floor toward -inf, no rounding); sat8 clamps to [-128,127].
  - Advance o; on o==D-1, o=0 and t increments.
  - acc <= b[new o] << FRAC.
  - Next state: DONE_PULSE if the written element was [N_TOK-1][D-1], else MAC.
- DONE_PULSE: done=1 for exactly one cycle; next state IDLE.
- Latency: D+1 = 17 cycles per element; 256*17 = 4352 cycles in MAC/WR. done is high in cycle 4353 after the edge that sampled start.
- start outside IDLE (busy or DONE_PULSE) is ignored. No queuing.
- x may change after the start edge (it is buffered). w and b are not buffered and must be held stable while busy=1.
- y elements update progressively during a run. y is guaranteed coherent only from the done pulse until the next accepted start. Elements not yet rewritten keep their previous values.
- Reset mid-run: immediate abort; all outputs return to reset values; no done pulse.
- Back-to-back runs: start may be asserted in the cycle after DONE_PULSE (state is IDLE again).

Test Plan:
- Identity: w[k*16+o]=0x10 when k==o else 0; b=0; x random -> y==x bit-exact; busy high 4353 cycles; done high exactly cycle 4353 after start, single cycle.
- Bias only: w all 0, b[o]=o-8 -> every row of y equals b; x content irrelevant.
- Saturation and truncation:
  - x=0x7F, w=0x7F, b=0x7F (all entries) -> every y=127.
  - x=0x80, w=0x7F, b=0x80 (all entries) -> every y=-128.
  - x[0][0]=0x01, w[0]=0x08, all else 0 -> y[0][0]=0.
  - x[0][0]=0xFF, w[0]=0x08, all else 0 -> y[0][0]=0xFF (-1, floor).
- Input buffering: change x every cycle after the start edge -> y matches the x sampled at start.
- start pulses at cycles 10, 2000 and 4353 after the first start -> only one done, at cycle 4353. A new start in the cycle after done is accepted and completes 4353 cycles later.
- Assert rst at cycle 1000 of a run -> y=0, busy=0, done=0 immediately. No done pulse appears. A subsequent start gives a correct full run.
